// File: rtl/i2c_cfg_master.sv
// Command-driven I2C register master: write 0..MAX_BYTES / read 1..MAX_BYTES.
// Define I2C_CLOCK_STRETCH_EN to honour slave clock stretching on i2c_scl_in.
module i2c_cfg_master #(
   parameter int CLK_DIV   = 125,
   parameter int MAX_BYTES = 4,
   parameter int LEN_W     = 4
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_rw,
   input  logic [6:0]             cmd_addr,
   input  logic [7:0]             cmd_reg,
   input  logic [LEN_W-1:0]       cmd_len,
   input  logic [8*MAX_BYTES-1:0] cmd_wdata,
   output logic [8*MAX_BYTES-1:0] rdata,
   output logic                   done,
   output logic                   ack_err,
   output logic                   busy,
   input  logic                   i2c_sda_in,
   input  logic                   i2c_scl_in,
   output logic                   i2c_sda_oe,
   output logic                   i2c_scl_oe
);
   localparam int DW = 8*MAX_BYTES;
   localparam int CW = $clog2(CLK_DIV);

   typedef enum logic [2:0] {
      IDLE, START, BYTE, ACK, RSTART, STOP, DONE
   } state_t;
   typedef enum logic [1:0] {P_ADDR, P_REG, P_DATA} phase_t;

   state_t           state;
   phase_t           phase;
   logic [CW-1:0]    div;
   logic [1:0]       q;
   logic [2:0]       bitcnt;
   logic [LEN_W-1:0] idx;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_c;
   logic             rw;
   logic             rx;
   logic             rd_sel;
   logic [6:0]       addr;
   logic [7:0]       regq;
   logic [DW-1:0]    wbuf;
   logic [7:0]       shreg;
   logic             samp;
   logic             active;
   logic             freeze;
   logic             tick;
   logic             slot_end;
   logic             last_byte;
   logic             sda_nxt;
   logic             scl_nxt;
   logic [7:0]       rx_byte;

`ifdef I2C_CLOCK_STRETCH_EN
   // Only count a low SCL as stretching once our own release is visible.
   assign freeze = (q == 2'd1 || q == 2'd2) && !i2c_scl_oe && !i2c_scl_in;
`else
   logic scl_in_unused;
   assign scl_in_unused = i2c_scl_in;
   assign freeze = 1'b0;
`endif

   assign active    = (state != IDLE) && (state != DONE);
   assign tick      = active && !freeze && (div == CW'(CLK_DIV-1));
   assign slot_end  = tick && (q == 2'd3);
   assign last_byte = (idx + 1'b1) == len;
   assign rx_byte   = {shreg[6:0], samp};
   assign busy      = ~cmd_ready;

   always_comb begin
      len_c = cmd_len;
      if (cmd_len > LEN_W'(MAX_BYTES))
         len_c = LEN_W'(MAX_BYTES);
      if (cmd_rw && cmd_len == '0)
         len_c = LEN_W'(1);
   end

   always_comb begin
      sda_nxt = 1'b0;
      scl_nxt = 1'b0;
      unique case (state)
         START, RSTART: begin
            sda_nxt = q[1];
            scl_nxt = (q == 2'd3);
         end
         BYTE: begin
            scl_nxt = (q == 2'd0) || (q == 2'd3);
            sda_nxt = !rx && !shreg[7];
         end
         ACK: begin
            scl_nxt = (q == 2'd0) || (q == 2'd3);
            sda_nxt = rx && !last_byte;
         end
         STOP: begin
            scl_nxt = (q == 2'd0);
            sda_nxt = (q != 2'd3);
         end
         default: begin
            sda_nxt = 1'b0;
            scl_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         state      <= IDLE;
         phase      <= P_ADDR;
         div        <= '0;
         q          <= '0;
         bitcnt     <= '0;
         idx        <= '0;
         len        <= '0;
         rw         <= 1'b0;
         rx         <= 1'b0;
         rd_sel     <= 1'b0;
         addr       <= '0;
         regq       <= '0;
         wbuf       <= '0;
         shreg      <= '0;
         samp       <= 1'b0;
         cmd_ready  <= 1'b1;
         done       <= 1'b0;
         ack_err    <= 1'b0;
         rdata      <= '0;
         i2c_sda_oe <= 1'b0;
         i2c_scl_oe <= 1'b0;
      end else begin
         done       <= 1'b0;
         i2c_sda_oe <= sda_nxt;
         i2c_scl_oe <= scl_nxt;
         if (tick) begin
            div <= '0;
            q   <= q + 2'd1;
            if (q == 2'd1)
               samp <= i2c_sda_in;
         end else if (active && !freeze) begin
            div <= div + 1'b1;
         end
         unique case (state)
            IDLE, DONE: begin
               state <= IDLE;
               if (cmd_valid) begin
                  state     <= START;
                  cmd_ready <= 1'b0;
                  ack_err   <= 1'b0;
                  rw        <= cmd_rw;
                  addr      <= cmd_addr;
                  regq      <= cmd_reg;
                  wbuf      <= cmd_wdata;
                  len       <= len_c;
                  phase     <= P_ADDR;
                  rx        <= 1'b0;
                  rd_sel    <= 1'b0;
                  div       <= '0;
                  q         <= '0;
                  if (cmd_rw)
                     rdata <= '0;
               end
            end
            START, RSTART: if (slot_end) begin
               state  <= BYTE;
               bitcnt <= '0;
               phase  <= P_ADDR;
               shreg  <= {addr, state == RSTART};
               rd_sel <= (state == RSTART);
            end
            BYTE: if (slot_end) begin
               shreg  <= rx ? rx_byte : {shreg[6:0], 1'b0};
               bitcnt <= bitcnt + 3'd1;
               if (bitcnt == 3'd7) begin
                  state <= ACK;
                  if (rx)
                     for (int i = 0; i < MAX_BYTES; i++)
                        if (idx == LEN_W'(i))
                           rdata[8*i +: 8] <= rx_byte;
               end
            end
            ACK: if (slot_end) begin
               bitcnt <= '0;
               state  <= BYTE;
               if (rx) begin
                  idx <= idx + 1'b1;
                  if (last_byte)
                     state <= STOP;
               end else if (samp) begin
                  ack_err <= 1'b1;
                  state   <= STOP;
               end else begin
                  unique case (phase)
                     P_ADDR: begin
                        if (rd_sel) begin
                           phase <= P_DATA;
                           rx    <= 1'b1;
                           idx   <= '0;
                        end else begin
                           phase <= P_REG;
                           shreg <= regq;
                        end
                     end
                     P_REG: begin
                        if (rw)
                           state <= RSTART;
                        else if (len == '0)
                           state <= STOP;
                        else begin
                           shreg <= wbuf[7:0];
                           wbuf  <= wbuf >> 8;
                           idx   <= '0;
                           phase <= P_DATA;
                        end
                     end
                     P_DATA: begin
                        idx <= idx + 1'b1;
                        if (last_byte)
                           state <= STOP;
                        else begin
                           shreg <= wbuf[7:0];
                           wbuf  <= wbuf >> 8;
                        end
                     end
                     default: state <= STOP;
                  endcase
               end
            end
            STOP: if (slot_end) begin
               done      <= 1'b1;
               cmd_ready <= 1'b1;
               state     <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_i2c_cfg_master.sv
// Directed bench for i2c_cfg_master with a bit-level I2C slave model.
// Covers write, NACK abort, read, len 0, clamping, reset abort, stretching.
module tb_i2c_cfg_master;
   localparam int CLK_DIV   = 4;
   localparam int MAX_BYTES = 4;
   localparam int LEN_W     = 4;
   localparam int SLOT      = 4*CLK_DIV;

   logic          clk_clk = 1'b0;
   logic          reset_reset = 1'b1;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_rw = 1'b0;
   logic [6:0]    cmd_addr = '0;
   logic [7:0]    cmd_reg = '0;
   logic [3:0]    cmd_len = '0;
   logic [31:0]   cmd_wdata = '0;
   logic [31:0]   rdata;
   logic          done;
   logic          ack_err;
   logic          busy;
   logic          i2c_sda_in;
   logic          i2c_scl_in;
   logic          i2c_sda_oe;
   logic          i2c_scl_oe;

   logic          stretch = 1'b0;
   logic          slave_sda;
   logic          scl_line;
   logic          sda_line;
   logic          nack_addr = 1'b0;

   int checks = 0;
   int errors = 0;

   i2c_cfg_master #(
      .CLK_DIV(CLK_DIV), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)
   ) dut (
      .clk_clk(clk_clk), .reset_reset(reset_reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_reg(cmd_reg),
      .cmd_len(cmd_len), .cmd_wdata(cmd_wdata), .rdata(rdata),
      .done(done), .ack_err(ack_err), .busy(busy),
      .i2c_sda_in(i2c_sda_in), .i2c_scl_in(i2c_scl_in),
      .i2c_sda_oe(i2c_sda_oe), .i2c_scl_oe(i2c_scl_oe)
   );

   always #5 clk_clk = ~clk_clk;

   assign i2c_scl_in = ~i2c_scl_oe & ~stretch;
`ifdef I2C_CLOCK_STRETCH_EN
   assign scl_line = ~i2c_scl_oe & ~stretch;
`else
   assign scl_line = ~i2c_scl_oe;
`endif
   assign sda_line   = ~(i2c_sda_oe | slave_sda);
   assign i2c_sda_in = sda_line;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // slave model: bits = -1 right after a START, 0..7 data, 8 ack slot
   logic          prev_scl = 1'b1;
   logic          prev_sda = 1'b1;
   int            bits = 0;
   int            byte_no = 0;
   logic [7:0]    sh = '0;
   logic [7:0]    txb = '0;
   logic          reading = 1'b0;
   logic          rd_next = 1'b0;
   int            nstart = 0;
   int            nstop = 0;
   int            rd_idx = 0;
   logic [7:0]    rd_data [0:7];
   logic [7:0]    got_q [$];
   logic          mack_q [$];

   initial slave_sda = 1'b0;

   always @(posedge clk_clk) begin
      prev_scl <= scl_line;
      prev_sda <= sda_line;
      if (reset_reset) begin
         bits <= 0; byte_no <= 0; reading <= 1'b0;
         rd_next <= 1'b0; slave_sda <= 1'b0; rd_idx <= 0;
      end else if (scl_line && prev_scl && prev_sda && !sda_line) begin
         nstart <= nstart + 1;
         bits <= -1; byte_no <= 0; reading <= 1'b0;
         rd_next <= 1'b0; slave_sda <= 1'b0;
      end else if (scl_line && prev_scl && !prev_sda && sda_line) begin
         nstop <= nstop + 1;
         reading <= 1'b0; slave_sda <= 1'b0; rd_idx <= 0;
      end else if (scl_line && !prev_scl) begin
         if (bits >= 0 && bits < 8)
            sh <= {sh[6:0], sda_line};
         else if (bits == 8 && reading)
            mack_q.push_back(sda_line);
      end else if (!scl_line && prev_scl) begin
         if (bits < 0) begin
            bits <= 0;
         end else if (bits < 7) begin
            bits <= bits + 1;
            if (reading)
               slave_sda <= ~txb[6-bits];
         end else if (bits == 7) begin
            bits <= 8;
            if (reading) begin
               slave_sda <= 1'b0;
            end else begin
               got_q.push_back(sh);
               slave_sda <= !(byte_no == 0 && nack_addr);
               rd_next <= (byte_no == 0) && sh[0];
            end
         end else begin
            bits <= 0;
            byte_no <= byte_no + 1;
            rd_next <= 1'b0;
            if (rd_next || (reading && mack_q[$] == 1'b0)) begin
               reading <= 1'b1;
               txb <= rd_data[rd_idx];
               slave_sda <= ~rd_data[rd_idx][7];
               rd_idx <= rd_idx + 1;
            end else begin
               reading <= 1'b0;
               slave_sda <= 1'b0;
            end
         end
      end
   end

   task automatic run_cmd(input string tag, input logic rw,
                          input logic [6:0] a, input logic [7:0] r,
                          input logic [3:0] len, input logic [31:0] wd,
                          input int exp_cyc);
      int n;
      @(posedge clk_clk); #1;
      cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a;
      cmd_reg = r; cmd_len = len; cmd_wdata = wd;
      @(posedge clk_clk); #1;
      cmd_valid = 1'b0;
      check({tag, "_ready_low"}, cmd_ready, 1'b0);
      check({tag, "_busy"}, busy, 1'b1);
      n = 0;
      while (!done && n < 3000) begin
         @(posedge clk_clk); #1;
         n++;
      end
      check({tag, "_latency"}, n, exp_cyc);
      check({tag, "_ready_done"}, cmd_ready, 1'b1);
   endtask

   initial begin
      int s0;
      int p0;
      int dseen;
      repeat (3) @(posedge clk_clk);
      #1;
      check("rst_sda_oe", i2c_sda_oe, 1'b0);
      check("rst_scl_oe", i2c_scl_oe, 1'b0);
      check("rst_ready", cmd_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ack_err", ack_err, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      reset_reset = 1'b0;

      // single-byte write
      got_q.delete(); s0 = nstart; p0 = nstop;
      run_cmd("wr1", 1'b0, 7'h39, 8'h41, 4'd1, 32'h10, 29*SLOT);
      check("wr1_ack_err", ack_err, 1'b0);
      check("wr1_nbytes", got_q.size(), 3);
      check("wr1_b0", got_q[0], 8'h72);
      check("wr1_b1", got_q[1], 8'h41);
      check("wr1_b2", got_q[2], 8'h10);
      check("wr1_starts", nstart - s0, 1);
      check("wr1_stops", nstop - p0, 1);
      @(posedge clk_clk); #1;
      check("wr1_done_pulse", done, 1'b0);
      check("wr1_idle_oe", {i2c_sda_oe, i2c_scl_oe}, 2'b00);

      // address NACK aborts to STOP
      nack_addr = 1'b1;
      got_q.delete(); p0 = nstop;
      run_cmd("nack", 1'b0, 7'h39, 8'h41, 4'd2, 32'h2211, 11*SLOT);
      check("nack_ack_err", ack_err, 1'b1);
      check("nack_nbytes", got_q.size(), 1);
      check("nack_stops", nstop - p0, 1);
      nack_addr = 1'b0;
      repeat (5) @(posedge clk_clk);
      #1;
      check("nack_err_hold", ack_err, 1'b1);

      // two-byte read with repeated start
      rd_data[0] = 8'hA5; rd_data[1] = 8'h3C;
      rd_data[2] = 8'h77; rd_data[3] = 8'h88;
      got_q.delete(); mack_q.delete(); s0 = nstart;
      run_cmd("rd2", 1'b1, 7'h39, 8'h00, 4'd2, 32'h0, 48*SLOT);
      check("rd2_ack_err", ack_err, 1'b0);
      check("rd2_rdata", rdata, 32'h0000_3CA5);
      check("rd2_nbytes", got_q.size(), 3);
      check("rd2_b0", got_q[0], 8'h72);
      check("rd2_b1", got_q[1], 8'h00);
      check("rd2_b2", got_q[2], 8'h73);
      check("rd2_starts", nstart - s0, 2);
      check("rd2_nmack", mack_q.size(), 2);
      check("rd2_mack", {mack_q[0], mack_q[1]}, 2'b01);

      // zero-length write
      got_q.delete();
      run_cmd("wr0", 1'b0, 7'h39, 8'h41, 4'd0, 32'h0, 20*SLOT);
      check("wr0_ack_err", ack_err, 1'b0);
      check("wr0_nbytes", got_q.size(), 2);
      check("wr0_b1", got_q[1], 8'h41);
      check("wr0_rdata_hold", rdata, 32'h0000_3CA5);

      // oversize length clamps to MAX_BYTES
      got_q.delete();
      run_cmd("clamp", 1'b0, 7'h20, 8'h05, 4'd15, 32'h4433_2211,
              (29 + 9*3)*SLOT);
      check("clamp_nbytes", got_q.size(), 6);
      check("clamp_b2", got_q[2], 8'h11);
      check("clamp_b5", got_q[5], 8'h44);

      // reset in the middle of a data byte
      dseen = 0;
      @(posedge clk_clk); #1;
      cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 7'h39;
      cmd_reg = 8'h41; cmd_len = 4'd2; cmd_wdata = 32'hBBAA;
      @(posedge clk_clk); #1;
      cmd_valid = 1'b0;
      for (int i = 0; i < 20*SLOT; i++) begin
         @(posedge clk_clk); #1;
         if (done) dseen++;
      end
      reset_reset = 1'b1;
      @(posedge clk_clk); #1;
      check("mrst_oe", {i2c_sda_oe, i2c_scl_oe}, 2'b00);
      check("mrst_ready", cmd_ready, 1'b1);
      check("mrst_busy", busy, 1'b0);
      check("mrst_ack_err", ack_err, 1'b0);
      reset_reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk_clk); #1;
         if (done) dseen++;
      end
      check("mrst_no_done", dseen, 0);
      got_q.delete();
      run_cmd("after_rst", 1'b0, 7'h39, 8'h41, 4'd1, 32'h10, 29*SLOT);
      check("after_rst_nbytes", got_q.size(), 3);
      check("after_rst_b2", got_q[2], 8'h10);

      // slave holds SCL low 50 cycles after one release
      got_q.delete();
      fork
`ifdef I2C_CLOCK_STRETCH_EN
         run_cmd("stretch", 1'b0, 7'h39, 8'h41, 4'd1, 32'h10, 29*SLOT + 50);
`else
         run_cmd("stretch", 1'b0, 7'h39, 8'h41, 4'd1, 32'h10, 29*SLOT);
`endif
         begin
            int k;
            logic p;
            repeat (150) @(posedge clk_clk);
            #1;
            k = 0;
            p = i2c_scl_oe;
            while (k < 64) begin
               @(posedge clk_clk); #1;
               k++;
               if (p && !i2c_scl_oe) break;
               p = i2c_scl_oe;
            end
            stretch = 1'b1;
            repeat (50) @(posedge clk_clk);
            #1;
            stretch = 1'b0;
         end
      join
      check("stretch_ack_err", ack_err, 1'b0);
      check("stretch_nbytes", got_q.size(), 3);
      check("stretch_b2", got_q[2], 8'h10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/i2c_cfg_master.md
# i2c_cfg_master

Parametrised I2C master that replaces the fixed single-port I2C serial pins of the soft-processor system with a standalone, command-driven engine. It configures the HDMI transmitter and other on-board I2C devices without processor involvement. The block accepts one register-level transaction per command (write of 0..MAX_BYTES data bytes, or register read of 1..MAX_BYTES bytes). It drives SCL/SDA through open-drain output-enables and reports ACK errors.

## Interface
- CLK_DIV, 125: clk_clk cycles per SCL quarter-period; SCL period = 4*CLK_DIV. Must be ≥ 2.
- MAX_BYTES, 4: maximum data bytes per command, 1..8.
- LEN_W, 4: width of cmd_len; must hold MAX_BYTES.
---
- clk_clk  in  1  system clock.
- reset_reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready.
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_addr  in  7  7-bit slave address.
- cmd_reg  in  8  register sub-address.
- cmd_len  in  LEN_W  data byte count; write 0..MAX_BYTES, read 1..MAX_BYTES.
- cmd_wdata  in  8*MAX_BYTES  write bytes, byte 0 = [7:0] sent first.
- rdata  out  8*MAX_BYTES  read bytes, byte 0 = [7:0] received first; unread bytes zero.
- done  out  1  one-cycle pulse at transaction end.
- ack_err  out  1  valid with done; 1 = a slave NACK occurred.
- busy  out  1  transaction in progress (= ~cmd_ready).
- i2c_sda_in  in  1  SDA line level.
- i2c_scl_in  in  1  SCL line level.
- i2c_sda_oe  out  1  1 = pull SDA low.
- i2c_scl_oe  out  1  1 = pull SCL low.

## Operation
- Commands are latched on acceptance. Out-of-range cmd_len is clamped to MAX_BYTES (read len 0 is treated as 1).
- States: IDLE, START, BYTE (8 bit slots), ACK (1 slot), RSTART, STOP, DONE.
- Write sequence: S, addr+0, A, reg, A, len data bytes each + A, P.
- Read sequence: S, addr+0, A, reg, A, Sr, addr+1, A, len bytes. The master ACKs each byte except the last, which gets a NACK. Then P.
- Slot = 4 quarters:
  - q0: SCL low, SDA set.
  - q1: SCL released.
  - q2: SCL high, sample SDA at q2 start.
  - q3: SCL low at end.
- START/RSTART slot: SDA released with SCL released, then SDA pulled low while SCL high, then SCL low.
- STOP slot: SDA low, SCL released, then SDA released while SCL high.
- Slave NACK (sampled SDA = 1 in any slave ACK slot): abort remaining bytes, go straight to STOP, ack_err = 1.
- rdata is updated byte-wise as each read byte completes and holds until the next read is accepted; it is cleared to 0 on acceptance of a read.
- DONE lasts one cycle (done = 1), then IDLE.
- Bus idle: both OEs 0.

## Timing
- Reset values: i2c_sda_oe = 0, i2c_scl_oe = 0, cmd_ready = 1, busy = 0, done = 0, ack_err = 0, rdata = 0; state IDLE, divider 0.
- cmd_ready falls the cycle after acceptance; cmd_valid is ignored while busy.
- Write of len bytes: done asserts (29 + 9*(len−1))*4*CLK_DIV cycles after the accept cycle (len = 0: 20 slots). cmd_ready rises together with done.
- Read of len bytes: (30 + 9*len)*4*CLK_DIV cycles.
- NACK abort: done at the end of the STOP slot that follows the failing ACK slot.
- Reset mid-transaction: OEs released in the following cycle; no STOP is generated; ack_err cleared; no done pulse.
- ack_err is held until the next acceptance.

## Configuration
- I2C_CLOCK_STRETCH_EN defined: in q1/q2, the divider is frozen while i2c_scl_in = 0 after SCL is released (slave stretching); timing figures are extended by the stretch duration.
- Undefined: i2c_scl_in is ignored and timing is exact as stated.

## Test plan
- Write addr 0x39, reg 0x41, len 1, data 0x10, slave ACKs, CLK_DIV 4 -> bytes 0x72, 0x41, 0x10 on SDA; done at cycle 464 after accept; ack_err = 0.
- Write addr 0x39 with slave NACK on address -> no reg byte sent; STOP follows; done with ack_err = 1 at 11 slots (176 cycles).
- Read addr 0x39, reg 0x00, len 2, slave returns 0xA5, 0x3C -> Sr then 0x73 on the bus; master ACK then NACK; rdata[15:0] = 0x3CA5; done at 48 slots.
- Write len 0 -> 20 slots, only address + register sent, done with ack_err = 0.
- reset_reset asserted mid data byte -> both OEs 0 the next cycle; cmd_ready = 1; no done; a fresh command then completes normally.
- With I2C_CLOCK_STRETCH_EN, slave holds SCL low 50 cycles in one bit -> done is delayed by exactly 50 cycles and the data is unchanged.
